// File: rtl/mac_seq_if.sv
// mac_seq_if: command, result, operand-memory and ALU-side signals of the
// dot-product sequencer, bundled so the sequencer and its environment share
// one typed connection.
interface mac_seq_if #(
   parameter int REG_DATA_WIDTH = 16,
   parameter int ADDR_WIDTH     = 8,
   parameter int LEN_WIDTH      = 8
);
   // command / status
   logic                      start;
   logic [ADDR_WIDTH-1:0]     base_a;
   logic [ADDR_WIDTH-1:0]     base_b;
   logic [LEN_WIDTH-1:0]      len;
   logic                      busy;
   logic                      done;
   logic [REG_DATA_WIDTH-1:0] result;
   // operand memories (synchronous read, one cycle of latency)
   logic [ADDR_WIDTH-1:0]     mem_a_addr;
   logic [ADDR_WIDTH-1:0]     mem_b_addr;
   logic [REG_DATA_WIDTH-1:0] mem_a_rdata;
   logic [REG_DATA_WIDTH-1:0] mem_b_rdata;
   // MAC ALU
   logic [REG_DATA_WIDTH-1:0] alu_rs1;
   logic [REG_DATA_WIDTH-1:0] alu_rs2;
   logic                      alu_funct;
   logic                      alu_mac_en;
   logic [REG_DATA_WIDTH-1:0] alu_rd;

   // environment side: issues commands, owns the memories and the ALU
   modport master (
      output start, base_a, base_b, len, mem_a_rdata, mem_b_rdata, alu_rd,
      input  busy, done, result, mem_a_addr, mem_b_addr,
             alu_rs1, alu_rs2, alu_funct, alu_mac_en
   );

   // sequencer side
   modport slave (
      input  start, base_a, base_b, len, mem_a_rdata, mem_b_rdata, alu_rd,
      output busy, done, result, mem_a_addr, mem_b_addr,
             alu_rs1, alu_rs2, alu_funct, alu_mac_en
   );
endinterface

// File: rtl/mac_seq.sv
// mac_seq: dot-product sequencer in front of the MAC ALU. A start command
// clears the ALU partial sum (INIT), then issues one multiply-accumulate per
// element (RUN) and captures the ALU result for a one-cycle done pulse.
module mac_seq #(
   parameter int REG_DATA_WIDTH = 16,
   parameter int ADDR_WIDTH     = 8,
   parameter int LEN_WIDTH      = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   mac_seq_if.slave   io_bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = LEN_WIDTH'(0);
   localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH:0]    LENX_TWO  = (LEN_WIDTH+1)'(2);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [REG_DATA_WIDTH-1:0] DATA_ZERO = REG_DATA_WIDTH'(0);

   state_t                    r_state;
   state_t                    w_next;
   logic [LEN_WIDTH-1:0]      r_len;
   logic [LEN_WIDTH-1:0]      r_idx;      // element currently in the ALU during RUN
   logic [ADDR_WIDTH-1:0]     r_addr_a;
   logic [ADDR_WIDTH-1:0]     r_addr_b;
   logic [REG_DATA_WIDTH-1:0] r_result;
   logic                      r_busy;
   logic                      r_done;

   logic                      w_last;     // current RUN cycle carries the final element
   logic                      w_more_init;
   logic                      w_more_run;
   logic [LEN_WIDTH:0]        w_idx_p2;

   logic [REG_DATA_WIDTH-1:0] w_alu_rs1;
   logic [REG_DATA_WIDTH-1:0] w_alu_rs2;
   logic                      w_alu_funct;
   logic                      w_alu_mac_en;

   // Address for element k+1 must already be on the bus during RUN cycle k,
   // so the counter is compared one and two elements ahead.
   assign w_last      = (r_idx == (r_len - LEN_ONE));
   assign w_more_init = (r_len > LEN_ONE);
   assign w_idx_p2    = {1'b0, r_idx} + LENX_TWO;
   assign w_more_run  = (w_idx_p2 < {1'b0, r_len});

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (io_bus.start) begin
               w_next = ST_INIT;
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_INIT: begin
            if (r_len == LEN_ZERO) begin
               w_next = ST_DONE;
            end else begin
               w_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (w_last) begin
               w_next = ST_DONE;
            end else begin
               w_next = ST_RUN;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   // ALU drive: INIT loads zero into the partial sum, RUN passes memory data
   // straight through (the read data arrives exactly in the RUN cycle).
   always_comb begin
      w_alu_rs1    = DATA_ZERO;
      w_alu_rs2    = DATA_ZERO;
      w_alu_funct  = 1'b0;
      w_alu_mac_en = 1'b0;
      case (r_state)
         ST_INIT: begin
            w_alu_funct  = 1'b1;
            w_alu_mac_en = 1'b1;
         end
         ST_RUN: begin
            w_alu_rs1    = io_bus.mem_a_rdata;
            w_alu_rs2    = io_bus.mem_b_rdata;
            w_alu_mac_en = 1'b1;
         end
         default: begin
            w_alu_mac_en = 1'b0;
         end
      endcase
   end

   // Command capture, element counter, addresses, result and status flags.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_len    <= LEN_ZERO;
         r_idx    <= LEN_ZERO;
         r_addr_a <= ADDR_ZERO;
         r_addr_b <= ADDR_ZERO;
         r_result <= DATA_ZERO;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_busy <= (w_next == ST_INIT) || (w_next == ST_RUN);
         r_done <= (w_next == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (io_bus.start) begin
                  r_len    <= io_bus.len;
                  r_idx    <= LEN_ZERO;
                  r_addr_a <= io_bus.base_a;
                  r_addr_b <= io_bus.base_b;
               end
            end
            ST_INIT: begin
               if (r_len == LEN_ZERO) begin
                  r_result <= DATA_ZERO;
               end else if (w_more_init) begin
                  r_addr_a <= r_addr_a + ADDR_ONE;
                  r_addr_b <= r_addr_b + ADDR_ONE;
               end
            end
            ST_RUN: begin
               if (w_last) begin
                  r_result <= io_bus.alu_rd;
               end else begin
                  r_idx <= r_idx + LEN_ONE;
                  if (w_more_run) begin
                     r_addr_a <= r_addr_a + ADDR_ONE;
                     r_addr_b <= r_addr_b + ADDR_ONE;
                  end
               end
            end
            default: begin
               r_idx <= r_idx;
            end
         endcase
      end
   end

   assign io_bus.busy       = r_busy;
   assign io_bus.done       = r_done;
   assign io_bus.result     = r_result;
   assign io_bus.mem_a_addr = r_addr_a;
   assign io_bus.mem_b_addr = r_addr_b;
   assign io_bus.alu_rs1    = w_alu_rs1;
   assign io_bus.alu_rs2    = w_alu_rs2;
   assign io_bus.alu_funct  = w_alu_funct;
   assign io_bus.alu_mac_en = w_alu_mac_en;

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: drives mac_seq with operand memories and a behavioural MAC ALU;
// expected dot products are queued at start and compared when done pulses.
module tb_mac_seq;

   logic clk;
   logic rst;

   mac_seq_if #(.REG_DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8)) bus ();

   mac_seq #(.REG_DATA_WIDTH(16), .ADDR_WIDTH(8), .LEN_WIDTH(8)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   logic [15:0] sb_q[$];

   logic [15:0] mem_a [0:255];
   logic [15:0] mem_b [0:255];
   logic [15:0] psum;

   // clock: 10 time-unit period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous-read operand memories
   always @(posedge clk) begin
      bus.mem_a_rdata <= mem_a[bus.mem_a_addr];
      bus.mem_b_rdata <= mem_b[bus.mem_b_addr];
   end

   // MAC ALU: funct=1 loads rs1, funct=0 accumulates truncated product
   assign bus.alu_rd = bus.alu_funct ? bus.alu_rs1 : 16'(psum + bus.alu_rs1 * bus.alu_rs2);
   always @(posedge clk) begin
      if (bus.alu_mac_en) psum <= bus.alu_rd;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // scoreboard: every done pops one expected result
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check_val("unexpected_done", 32'd1, 32'd0);
         end else begin
            check_val("result", 32'(bus.result), 32'(sb_q.pop_front()));
         end
      end
   end

   function automatic logic [15:0] dot_ref(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln);
      logic [15:0] acc;
      acc = 16'd0;
      for (int i = 0; i < int'(ln); i++) begin
         acc = acc + mem_a[8'(int'(ba) + i)] * mem_b[8'(int'(bb) + i)];
      end
      return acc;
   endfunction

   // one command with per-cycle checks of busy/done/ALU controls/addresses
   task automatic do_cmd(input logic [7:0] ba, input logic [7:0] bb, input logic [7:0] ln,
                         input logic [15:0] exp_res, input bit poke_start);
      int last_addr;
      logic [7:0] ea;
      logic [7:0] eb;
      last_addr = (ln == 8'd0) ? 1 : int'(ln);
      @(posedge clk); #1;
      bus.start  = 1'b1;
      bus.base_a = ba;
      bus.base_b = bb;
      bus.len    = ln;
      sb_q.push_back(exp_res);
      @(negedge clk);
      check_val("busy_t0", 32'(bus.busy), 32'd0);
      @(posedge clk); #1;
      bus.start  = 1'b0;
      bus.base_a = 8'hEE;
      bus.base_b = 8'hEE;
      bus.len    = 8'hFF;
      for (int c = 1; c <= int'(ln) + 2; c++) begin
         @(negedge clk);
         bus.start = (poke_start && c == 2) ? 1'b1 : 1'b0;
         check_val("busy",   32'(bus.busy),       32'(c <= int'(ln) + 1));
         check_val("mac_en", 32'(bus.alu_mac_en), 32'(c <= int'(ln) + 1));
         check_val("funct",  32'(bus.alu_funct),  32'(c == 1));
         check_val("done",   32'(bus.done),       32'(c == int'(ln) + 2));
         if (c <= last_addr) begin
            ea = 8'(int'(ba) + c - 1);
            eb = 8'(int'(bb) + c - 1);
            check_val("addr_a", 32'(bus.mem_a_addr), 32'(ea));
            check_val("addr_b", 32'(bus.mem_b_addr), 32'(eb));
         end
      end
      bus.start = 1'b0;
      @(negedge clk);
      check_val("idle_done", 32'(bus.done), 32'd0);
      check_val("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.base_a = 8'h00;
      bus.base_b = 8'h00;
      bus.len    = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'h0000;
         mem_b[i] = 16'h0000;
      end
      // basic vectors
      mem_a[8'h10] = 16'd2;      mem_a[8'h11] = 16'd3;      mem_a[8'h12] = 16'd4;
      mem_b[8'h20] = 16'd5;      mem_b[8'h21] = 16'd6;      mem_b[8'h22] = 16'd7;
      // signed
      mem_a[8'h30] = 16'hFFFD;   mem_a[8'h31] = 16'd7;
      mem_b[8'h50] = 16'd4;      mem_b[8'h51] = 16'hFFFE;
      mem_a[8'h60] = 16'd5;      mem_a[8'h61] = 16'hFFFF;
      mem_b[8'h70] = 16'd2;      mem_b[8'h71] = 16'd3;
      // wrap
      mem_a[8'hFE] = 16'd1;      mem_a[8'hFF] = 16'd2;
      mem_a[8'h00] = 16'd3;      mem_a[8'h01] = 16'd4;
      mem_b[8'h40] = 16'd1;      mem_b[8'h41] = 16'd1;
      mem_b[8'h42] = 16'd1;      mem_b[8'h43] = 16'd1;
      // overflow
      mem_a[8'h80] = 16'h7FFF;   mem_a[8'h81] = 16'h7FFF;
      mem_b[8'h90] = 16'd2;      mem_b[8'h91] = 16'd1;
      // aborted run and follow-up
      for (int i = 0; i < 5; i++) begin
         mem_a[8'hA0 + i] = 16'd9;
         mem_b[8'hB0 + i] = 16'd9;
      end
      mem_a[8'hC0] = 16'd3;      mem_b[8'hD0] = 16'd3;

      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_busy",   32'(bus.busy),       32'd0);
      check_val("rst_done",   32'(bus.done),       32'd0);
      check_val("rst_result", 32'(bus.result),     32'd0);
      check_val("rst_addr_a", 32'(bus.mem_a_addr), 32'd0);
      check_val("rst_addr_b", 32'(bus.mem_b_addr), 32'd0);
      check_val("rst_rs1",    32'(bus.alu_rs1),    32'd0);
      check_val("rst_rs2",    32'(bus.alu_rs2),    32'd0);
      check_val("rst_funct",  32'(bus.alu_funct),  32'd0);
      check_val("rst_mac_en", 32'(bus.alu_mac_en), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      do_cmd(8'h10, 8'h20, 8'd3, 16'h0038, 1'b1);   // 56, start poked in RUN
      do_cmd(8'h30, 8'h50, 8'd2, 16'hFFE6, 1'b0);   // -26
      do_cmd(8'h60, 8'h70, 8'd2, 16'h0007, 1'b0);   // independent second result
      do_cmd(8'h33, 8'h44, 8'd0, 16'h0000, 1'b0);   // empty vector
      do_cmd(8'hFE, 8'h40, 8'd4, 16'h000A, 1'b0);   // address wrap
      do_cmd(8'h80, 8'h90, 8'd2, 16'h7FFD, 1'b0);   // accumulate wrap
      check_val("result_held", 32'(bus.result), 32'h7FFD);

      // reset in the middle of a len=5 run: no done, outputs back to reset
      @(posedge clk); #1;
      bus.start = 1'b1; bus.base_a = 8'hA0; bus.base_b = 8'hB0; bus.len = 8'd5;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      check_val("abort_busy_t2", 32'(bus.busy), 32'd1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_val("abort_busy",   32'(bus.busy),       32'd0);
      check_val("abort_done",   32'(bus.done),       32'd0);
      check_val("abort_result", 32'(bus.result),     32'd0);
      check_val("abort_mac_en", 32'(bus.alu_mac_en), 32'd0);
      check_val("abort_addr_a", 32'(bus.mem_a_addr), 32'd0);
      repeat (8) @(posedge clk);
      do_cmd(8'hC0, 8'hD0, 8'd1, 16'h0009, 1'b0);   // 3*3 after abort

      // random commands checked against the reference dot product
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = 16'($urandom);
         mem_b[i] = 16'($urandom);
      end
      for (int r = 0; r < 4; r++) begin
         logic [7:0] ba;
         logic [7:0] bb;
         logic [7:0] ln;
         ba = 8'($urandom);
         bb = 8'($urandom);
         ln = 8'($urandom_range(20, 0));
         do_cmd(ba, bb, ln, dot_ref(ba, bb, ln), 1'b0);
      end

      repeat (3) @(posedge clk);
      check_val("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mac_seq.md
# mac_seq

Dot-product sequencer that sits directly upstream of the core's MAC ALU. On a start command it streams two operand vectors out of synchronous-read operand memories and drives the ALU's `rs1`/`rs2`/`funct`/`MacEn` inputs. It first clears the ALU's internal partial sum, then issues one multiply-accumulate per element. It captures the ALU's `rd` output after the last element and returns it as a 16-bit result with a one-cycle `done` pulse.

## Interface
- `REG_DATA_WIDTH`, 16, width of operands, ALU ports and result.
- `ADDR_WIDTH`, 8, operand-memory address width.
- `LEN_WIDTH`, 8, vector-length field width.

- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  command strobe; accepted only when `busy`=0.
- `base_a`  in  ADDR_WIDTH  start address of vector A.
- `base_b`  in  ADDR_WIDTH  start address of vector B.
- `len`  in  LEN_WIDTH  element count, 0..2^LEN_WIDTH-1.
- `busy`  out  1  high from the cycle after accept until the last MAC cycle, inclusive.
- `done`  out  1  one-cycle pulse when `result` becomes valid.
- `result`  out  REG_DATA_WIDTH  dot product; held until the next `done`.
- `mem_a_addr`, `mem_b_addr`  out  ADDR_WIDTH  operand-memory read addresses.
- `mem_a_rdata`, `mem_b_rdata`  in  REG_DATA_WIDTH  read data, valid 1 cycle after the address.
- `alu_rs1`, `alu_rs2`  out  REG_DATA_WIDTH  ALU operands.
- `alu_funct`  out  1  1 = load `rs1` into the partial sum, 0 = multiply-accumulate.
- `alu_mac_en`  out  1  ALU partial-sum write enable.
- `alu_rd`  in  REG_DATA_WIDTH  ALU combinational result.

## Operation
- FSM states: IDLE, INIT, RUN, DONE.
- IDLE: `start`=1 latches `base_a`, `base_b` and `len`, clears the index counter, and moves to INIT.
- INIT, one cycle:
  - Drives `alu_funct`=1, `alu_rs1`=0, `alu_mac_en`=1, which clears the ALU partial sum.
  - Presents `base_a` and `base_b` as the memory addresses (element 0).
  - Next state is DONE if `len`=0, otherwise RUN.
- RUN, exactly `len` cycles; cycle k carries element k:
  - `alu_funct`=0, `alu_mac_en`=1.
  - `alu_rs1`=`mem_a_rdata`, `alu_rs2`=`mem_b_rdata`, passed through combinationally.
  - Addresses for element k+1 are presented in the same cycle when k+1 < `len`.
  - On the last RUN cycle, `result` <= `alu_rd`, then the FSM moves to DONE.
- DONE, one cycle: `done`=1, then IDLE. With `len`=0, `result` <= 0 when entering DONE.
- Address for element i is `base + i` mod 2^ADDR_WIDTH; wrap-around is silent.
- Arithmetic is the ALU's: signed 16×16 product, truncated to the low REG_DATA_WIDTH bits, two's-complement wrap on accumulate. No saturation or overflow flag.
- Outside INIT/RUN: `alu_mac_en`=0, `alu_funct`=0, `alu_rs1`=`alu_rs2`=0. Address outputs hold their last value.
- `start` while busy or in DONE is ignored; there is no queueing.

## Timing
- Accept at cycle T0. INIT at T1. RUN at T2..T(len+1). `done` at T(len+2). Start-to-done latency is `len`+2 cycles.
- `len`=0: INIT at T1, `done` with `result`=0 at T2.
- `busy`=1 on T1..T(len+1); `busy`=0 in IDLE and DONE.
- Back-to-back: a new `start` is accepted in the cycle after `done`, i.e. when the FSM is back in IDLE.
- Reset values: FSM=IDLE, `busy`=0, `done`=0, `result`=0, both addresses 0, all `alu_*` outputs 0.
- Reset mid-operation:
  - Aborts on the next edge with all outputs at reset values and no `done`.
  - The ALU partial sum is not reset by this block; the INIT of the next command clears it.

## Test plan
- A=[2,3,4] and B=[5,6,7] at bases 0x10/0x20, `len`=3, start at T0 -> `busy` T1..T4, `alu_mac_en` T1..T4, `done` at T5, `result`=56 (0x0038).
- Signed: A=[-3, 7], B=[4, -2], `len`=2 -> `result`=-26 (0xFFE6); a second command without reset yields an independent result, proving INIT clears the partial sum.
- `len`=0 -> INIT at T1, `done` at T2, `result`=0, `alu_funct`=0 and `alu_mac_en`=0 at T2.
- Wrap: `base_a`=0xFE, `len`=4 -> `mem_a_addr` sequence 0xFE, 0xFF, 0x00, 0x01.
- Overflow: A=[0x7FFF, 0x7FFF], B=[2, 1], `len`=2 -> (0xFFFE + 0x7FFF) mod 2^16 = 0x7FFD.
- Control: `start` pulsed during RUN is ignored (single `done`). `rst` asserted at T2 of a `len`=5 run -> IDLE next cycle, no `done`, `result`=0. A following run of `len`=1 with A=[3], B=[3] -> `result`=9.
